// File: rtl/router_pkt_tx.sv
// Router packet source: buffers a whole payload, then sends header, payload and parity bytes, stalling while busy is high.
// Optional ROUTER_TX_PARITY_INJ_EN adds inj_err, which flips parity bit 0 of the packet it was sampled with.
module router_pkt_tx #(
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_addr,
  input  logic [5:0] req_len,
`ifdef ROUTER_TX_PARITY_INJ_EN
  input  logic       inj_err,
`endif
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_t;

  localparam logic [6:0] MAX_LEN_W = 7'(MAX_LEN);
  localparam logic [3:0] GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t     state_reg, state_next;
  logic [7:0] header_reg, header_next;
  logic [7:0] parity_reg, parity_next;
  logic [5:0] len_reg, len_next;
  logic [5:0] wr_cnt_reg, wr_cnt_next;
  logic [5:0] rd_cnt_reg, rd_cnt_next;
  logic [3:0] gap_cnt_reg, gap_cnt_next;
  logic       pkt_valid_reg, pkt_valid_next;
  logic [7:0] data_out_reg, data_out_next;
  logic       done_reg, done_next;
  logic       err_reg, err_next;

  logic [7:0] buf_mem [0:63];
  logic       buf_we;
  logic [5:0] rd_addr;
  logic [7:0] buf_rd;
  logic       req_legal;
  logic       req_accept;
  logic       parity_flip;

  assign req_ready  = (state_reg == IDLE);
  assign pl_ready   = (state_reg == LOAD);
  assign pkt_valid  = pkt_valid_reg;
  assign data_out   = data_out_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign req_legal  = (req_addr != 2'b11) && (req_len != 6'd0) && ({1'b0, req_len} <= MAX_LEN_W);
  assign req_accept = (state_reg == IDLE) && req_valid && req_legal;

`ifdef ROUTER_TX_PARITY_INJ_EN
  logic inj_reg;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)         inj_reg <= 1'b0;
    else if (req_accept) inj_reg <= inj_err;
  end
  assign parity_flip = inj_reg;
`else
  assign parity_flip = 1'b0;
`endif

  // Payload buffer is deliberately not reset; its read is captured by data_out_reg.
  always_ff @(posedge clock) begin
    if (buf_we) buf_mem[wr_cnt_reg] <= pl_data;
  end
  assign rd_addr = (state_reg == PAYLOAD) ? rd_cnt_reg + 6'd1 : 6'd0;
  assign buf_rd  = buf_mem[rd_addr];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      header_reg    <= 8'h00;
      parity_reg    <= 8'h00;
      len_reg       <= 6'd0;
      wr_cnt_reg    <= 6'd0;
      rd_cnt_reg    <= 6'd0;
      gap_cnt_reg   <= 4'd0;
      pkt_valid_reg <= 1'b0;
      data_out_reg  <= 8'h00;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      header_reg    <= header_next;
      parity_reg    <= parity_next;
      len_reg       <= len_next;
      wr_cnt_reg    <= wr_cnt_next;
      rd_cnt_reg    <= rd_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      pkt_valid_reg <= pkt_valid_next;
      data_out_reg  <= data_out_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  // Outputs are loaded on the edge that enters a state, so they line up with that state.
  always_comb begin
    state_next     = state_reg;
    header_next    = header_reg;
    parity_next    = parity_reg;
    len_next       = len_reg;
    wr_cnt_next    = wr_cnt_reg;
    rd_cnt_next    = rd_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    pkt_valid_next = pkt_valid_reg;
    data_out_next  = data_out_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    buf_we         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (req_legal) begin
            header_next = {req_len, req_addr};
            parity_next = {req_len, req_addr};
            len_next    = req_len;
            wr_cnt_next = 6'd0;
            state_next  = LOAD;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      LOAD: begin
        if (pl_valid) begin
          buf_we      = 1'b1;
          parity_next = parity_reg ^ pl_data;
          if (wr_cnt_reg == len_reg - 6'd1) begin
            state_next     = HEADER;
            pkt_valid_next = 1'b1;
            data_out_next  = header_reg;
          end else begin
            wr_cnt_next = wr_cnt_reg + 6'd1;
          end
        end
      end
      HEADER: begin
        if (!busy) begin
          state_next    = PAYLOAD;
          rd_cnt_next   = 6'd0;
          data_out_next = buf_rd;
        end
      end
      PAYLOAD: begin
        if (!busy) begin
          if (rd_cnt_reg == len_reg - 6'd1) begin
            state_next     = PARITY;
            pkt_valid_next = 1'b0;
            data_out_next  = parity_reg ^ {7'd0, parity_flip};
          end else begin
            rd_cnt_next   = rd_cnt_reg + 6'd1;
            data_out_next = buf_rd;
          end
        end
      end
      PARITY: begin
        if (!busy) begin
          done_next     = 1'b1;
          data_out_next = 8'h00;
          gap_cnt_next  = 4'd0;
          state_next    = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) state_next = IDLE;
        else                         gap_cnt_next = gap_cnt_reg + 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: expected wire bytes are queued at stimulus time and popped by a monitor.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_addr = 2'b00;
  logic [5:0] req_len = 6'd0;
  logic       inj_err = 1'b0;
  logic       pl_valid = 1'b0;
  logic       pl_ready;
  logic [7:0] pl_data = 8'h00;
  logic       busy = 1'b0;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       done;
  logic       err;

  always #5 clock = ~clock;

  router_pkt_tx dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
`ifdef ROUTER_TX_PARITY_INJ_EN
    .inj_err   (inj_err),
`endif
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .pl_data   (pl_data),
    .busy      (busy),
    .pkt_valid (pkt_valid),
    .data_out  (data_out),
    .done      (done),
    .err       (err)
  );

  typedef struct packed {
    logic       pv;
    logic [7:0] d;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      mon_e;
  int         errors = 0;
  int         checks = 0;
  logic       prev_pv = 1'b0;
  logic [7:0] pl_buf [0:63];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wire monitor: a data byte counts when pkt_valid=1 and busy=0; parity is the first cycle after pkt_valid falls.
  always @(negedge clock) begin
    if (!resetn) begin
      prev_pv <= 1'b0;
    end else begin
      prev_pv <= pkt_valid;
      if ((pkt_valid && !busy) || (!pkt_valid && prev_pv)) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_beat", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          check("wire_pkt_valid", {31'd0, pkt_valid}, {31'd0, mon_e.pv});
          check("wire_data", {24'd0, data_out}, {24'd0, mon_e.d});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 200) begin
      tick();
      n++;
    end
    if (!req_ready) check("req_ready_timeout", {31'd0, req_ready}, 1);
  endtask

  task automatic do_req(input logic [1:0] a, input logic [5:0] l, input logic inj);
    wait_ready();
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    inj_err   = inj;
    tick();
    req_valid = 1'b0;
    check("pl_ready_after_req", {31'd0, pl_ready}, 1);
    check("req_ready_after_req", {31'd0, req_ready}, 0);
    exp_q.push_back(beat_t'({1'b1, l, a}));
  endtask

  task automatic load(input int l, input bit toggle, input logic [7:0] hdr, input logic inj);
    logic [7:0] par;
    par = hdr;
    for (int i = 0; i < l; i++) begin
      exp_q.push_back(beat_t'({1'b1, pl_buf[i]}));
      par ^= pl_buf[i];
      if (i == 0) check("load_quiet", {31'd0, pkt_valid}, 0);
      pl_valid = 1'b1;
      pl_data  = pl_buf[i];
      tick();
      if (toggle && i != l - 1) begin
        pl_valid = 1'b0;
        tick();
      end
    end
    pl_valid = 1'b0;
    check("header_latency", {31'd0, pkt_valid}, 1);
    if (inj) par[0] = ~par[0];
    exp_q.push_back(beat_t'({1'b0, par}));
  endtask

  task automatic finish_pkt(input bit stall_en, input logic [7:0] stall_byte);
    int n = 0;
    bit stalled = 1'b0;
    while (!done && n < 500) begin
      if (stall_en && !stalled && pkt_valid && data_out == stall_byte) begin
        stalled = 1'b1;
        busy = 1'b1;
        tick();
        check("stall_hold1_data", {24'd0, data_out}, {24'd0, stall_byte});
        check("stall_hold1_pv", {31'd0, pkt_valid}, 1);
        tick();
        check("stall_hold2_data", {24'd0, data_out}, {24'd0, stall_byte});
        check("stall_hold2_pv", {31'd0, pkt_valid}, 1);
        busy = 1'b0;
      end
      tick();
      n++;
    end
    if (stall_en && !stalled) check("stall_byte_seen", {31'd0, stalled}, 1);
    if (!done) begin
      check("done_timeout", {31'd0, done}, 1);
    end else begin
      check("gap1_pv", {31'd0, pkt_valid}, 0);
      check("gap1_data", {24'd0, data_out}, 0);
      check("gap1_req_ready", {31'd0, req_ready}, 0);
      tick();
      check("done_one_cycle", {31'd0, done}, 0);
      check("gap2_req_ready", {31'd0, req_ready}, 0);
      check("gap2_data", {24'd0, data_out}, 0);
      tick();
      check("idle_req_ready", {31'd0, req_ready}, 1);
    end
  endtask

  task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input bit toggle,
                         input logic inj, input bit stall_en, input logic [7:0] stall_byte);
    do_req(a, l, inj);
    load(int'(l), toggle, {l, a}, inj);
    finish_pkt(stall_en, stall_byte);
    $display("pkt addr=%0d len=%0d toggle=%0d inj=%0d stall=%0d errors=%0d", a, l, toggle, inj, stall_en, errors);
  endtask

  task automatic set_123();
    pl_buf[0] = 8'h11;
    pl_buf[1] = 8'h22;
    pl_buf[2] = 8'h33;
  endtask

  task automatic bad_req(input logic [1:0] a, input logic [5:0] l);
    wait_ready();
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    tick();
    req_valid = 1'b0;
    check("bad_err_pulse", {31'd0, err}, 1);
    check("bad_req_ready", {31'd0, req_ready}, 1);
    check("bad_pl_ready", {31'd0, pl_ready}, 0);
    check("bad_pkt_valid", {31'd0, pkt_valid}, 0);
    tick();
    check("bad_err_cleared", {31'd0, err}, 0);
    check("bad_pl_ready2", {31'd0, pl_ready}, 0);
    $display("bad req addr=%0d len=%0d errors=%0d", a, l, errors);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #3;
    check("rst_pkt_valid", {31'd0, pkt_valid}, 0);
    check("rst_data_out", {24'd0, data_out}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_req_ready", {31'd0, req_ready}, 1);
    check("rst_pl_ready", {31'd0, pl_ready}, 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();

    set_123();
    run_pkt(2'b01, 6'd3, 1'b0, 1'b0, 1'b0, 8'h00);
    run_pkt(2'b01, 6'd3, 1'b0, 1'b0, 1'b1, 8'h22);

    bad_req(2'b11, 6'd5);
    bad_req(2'b00, 6'd0);

    for (int i = 0; i < 63; i++) pl_buf[i] = 8'($urandom_range(0, 255));
    run_pkt(2'b10, 6'd63, 1'b1, 1'b0, 1'b0, 8'h00);

    pl_buf[0] = 8'h5A;
    run_pkt(2'b00, 6'd1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Reset in the middle of the second payload byte.
    set_123();
    do_req(2'b01, 6'd3, 1'b0);
    load(3, 1'b0, 8'h0D, 1'b0);
    n = 0;
    while (!(pkt_valid && data_out == 8'h22) && n < 50) begin
      tick();
      n++;
    end
    check("abort_byte_seen", {24'd0, data_out}, 32'h22);
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_pkt_valid", {31'd0, pkt_valid}, 0);
    check("async_rst_data_out", {24'd0, data_out}, 0);
    exp_q.delete();
    tick();
    resetn = 1'b1;
    tick();
    check("post_rst_req_ready", {31'd0, req_ready}, 1);
    check("post_rst_pl_ready", {31'd0, pl_ready}, 0);
    $display("abort by reset mid-packet errors=%0d", errors);
    run_pkt(2'b01, 6'd3, 1'b0, 1'b0, 1'b0, 8'h00);

`ifdef ROUTER_TX_PARITY_INJ_EN
    run_pkt(2'b01, 6'd3, 1'b0, 1'b1, 1'b0, 8'h00);
    run_pkt(2'b01, 6'd3, 1'b0, 1'b0, 1'b0, 8'h00);
`endif

    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet source for the router input port. Accepts a transmit request (destination address plus length) and a payload byte stream, then buffers the whole payload. It then drives the router byte protocol:
- header byte, then payload bytes, all with pkt_valid=1;
- then the parity byte with pkt_valid=0;
- stalls while the router asserts busy.
Used as the traffic generator in front of the router top and as the packet driver for the host-side bridge.

Parameters:
MAX_LEN, 63, largest legal payload length in bytes (1..63; header length field is 6 bits).
GAP_CYCLES, 2, idle cycles (pkt_valid=0, data_out=0) forced after each parity byte before the next request is accepted (0..15).

Ports:
clock  input  1  system clock, all state on rising edge.
resetn  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  request accepted this cycle when req_valid=1; decoded as state==IDLE.
req_addr  input  2  destination port; 2'b11 is illegal.
req_len  input  6  payload length in bytes.
pl_valid  input  1  payload byte present.
pl_ready  output  1  asserted only in LOAD.
pl_data  input  8  payload byte.
busy  input  1  router busy; freezes transmission.
pkt_valid  output  1  router packet-valid, registered.
data_out  output  8  router data byte, registered.
done  output  1  one-cycle pulse when the parity byte completes.
err  output  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset values: pkt_valid=0, data_out=8'h00, done=0, err=0, state=IDLE, counters=0, parity accumulator=0. Buffer RAM is not reset.
- A reset assertion at any time (including mid-packet) takes effect immediately: pkt_valid drops at once and the partial packet is abandoned.
- FSM states: IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
- IDLE: req_ready=1.
  - On req_valid with illegal fields (addr==2'b11, len==0, or len>MAX_LEN): err=1 the next cycle; stay in IDLE.
  - Otherwise latch header={req_len,req_addr}, set parity accumulator=header, go to LOAD.
- LOAD: pl_ready=1.
  - Each pl_valid byte is written to buf[wr_cnt] and XORed into parity.
  - The final byte (wr_cnt==len-1) moves the FSM to HEADER.
  - Gaps in pl_valid are allowed; no output activity during LOAD.
- HEADER: data_out=header, pkt_valid=1.
- PAYLOAD: data_out=buf[rd_cnt], pkt_valid=1.
  - Advances when busy=0.
  - After byte len-1 is accepted, goes to PARITY.
- PARITY: data_out=parity accumulator, pkt_valid=0.
  - Held until busy=0; then done=1 for one cycle and the FSM goes to GAP.
- GAP: pkt_valid=0, data_out=0 for GAP_CYCLES cycles, then IDLE. If GAP_CYCLES=0, go directly to IDLE.
- Busy handling: busy is sampled every cycle in HEADER, PAYLOAD and PARITY. While busy=1, data_out, pkt_valid and all counters hold. busy is ignored in the other states.
- Latency:
  - Request accepted at edge N: first pl_ready at cycle N+1.
  - Last payload byte accepted at edge M: header on data_out from M+1.
  - Minimum packet length on the wire is len+2 cycles.
- Parity = XOR of header and all payload bytes, 8 bits.

Optional Feature:
Macro: ROUTER_TX_PARITY_INJ_EN.
- Defined: adds input inj_err (1 bit), sampled at request acceptance. If it was 1, the transmitted parity byte has bit 0 inverted, to exercise the router error flag.
- Undefined: the port is absent and parity is always correct.

Test Plan:
1. addr=01, len=3, payload 11,22,33, busy=0 -> data_out 0D,11,22,33 with pkt_valid=1, then 0D with pkt_valid=0; done pulses; then 2 gap cycles.
2. As case 1 with busy=1 for 2 cycles while 22 is driven -> 22 held 3 cycles, pkt_valid stays 1, parity still 0D.
3. req_addr=11, len=5 -> err pulses one cycle, req_ready stays 1, pl_ready stays 0, pkt_valid stays 0.
4. addr=10, len=63, pl_valid toggling every other cycle -> header FE, 63 bytes in order, parity = FE XOR all payload bytes.
5. resetn low while the 2nd payload byte is driven -> pkt_valid=0 and data_out=00 without waiting for a clock edge; after release req_ready=1 and a new packet transmits correctly.
6. With ROUTER_TX_PARITY_INJ_EN defined, inj_err=1 on case 1 -> parity byte 0C; with inj_err=0 -> 0D.
